mux4_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-input datapath mux (a `mux4` instance) between four requesters. It grants exclusive ownership to one requester at a time and drives the mux `control` select with the owner's index. Ownership is held until the owner drops its request. It sits between the requesting units and the shared bus and is the sole driver of that mux's select lines.

---
 rtl/mux4_arbiter_pkg.sv | 13 +
 rtl/mux4_arbiter_rr_pick4.sv | 27 ++
 rtl/mux4_arbiter.sv | 118 +++++++++++
 tb/tb_mux4_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux4_arbiter_pkg.sv
// Shared encodings and constants for the mux4 round-robin arbiter.
package mux4_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int         NUM_REQ  = 4;
  localparam int         SEL_W    = 2;
  localparam logic [1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/mux4_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request after `last`, wrapping mod 4.
module rr_pick4
  import mux4_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   win_idx,
  output logic               any
);

  logic [SEL_W-1:0] w_cand;

  always_comb begin
    win_idx = last;
    any     = 1'b0;
    w_cand  = last;
    // k = 4 wraps back to `last` itself, so the previous owner is searched last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = last + SEL_W'(k);
      if (!any && req[w_cand]) begin
        win_idx = w_cand;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin owner arbiter driving the shared mux4 select.
// Optional hold limit with forced release enabled by MUX4_ARB_TIMEOUT_EN.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("mux4_arbiter: MAX_HOLD must be in 2..256");
  end

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [SEL_W-1:0]   r_last, w_last_nxt;
  logic [SEL_W-1:0]   w_win_idx;
  logic               w_any;

  rr_pick4 u_pick (
    .req     (req),
    .last    (r_last),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= LAST_RST;
`ifdef MUX4_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
`ifdef MUX4_ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
`ifdef MUX4_ARB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_OWNED;
          w_gnt_nxt   = NUM_REQ'(1) << w_win_idx;
          w_sel_nxt   = w_win_idx;
`ifdef MUX4_ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      ARB_OWNED: begin
        // A normal release wins over the hold limit, so no timeout pulse then.
        if (!req[r_sel]) begin
          w_state_nxt = ARB_IDLE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_sel;
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (r_cnt == HOLD_LAST) begin
          w_state_nxt   = ARB_IDLE;
          w_gnt_nxt     = '0;
          w_last_nxt    = r_sel;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = |r_gnt;
`ifdef MUX4_ARB_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: reset, round-robin, wrap, hold, mid-grant reset, timeout.
module tb_mux4_arbiter;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  mux4_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                         input logic e_busy, input logic e_to);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".sel"}, {2'b00, sel}, {2'b00, e_sel});
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, e_busy});
    chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, e_to});
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] nxt_g;

    // 1. reset held with all requests up
    reset = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 2. round-robin: each owner holds 3 cycles then drops for one
    for (int i = 0; i < 4; i++) begin
      exp_g = 4'b0001 << i;
      nxt_g = 4'b0001 << ((i + 1) % 4);
      tick();
      chk("rr_hold2", gnt, exp_g);
      tick();
      chk("rr_hold3", gnt, exp_g);
      req = 4'b1111 & ~exp_g;
      tick();
      chk_all("rr_release", 4'b0000, 2'(i), 1'b0, 1'b0);
      req = 4'b1111;
      tick();
      chk_all("rr_next", nxt_g, 2'((i + 1) % 4), 1'b1, 1'b0);
    end

    // 3. wrap: last=2, req=0011 -> requester 0
    req = 4'b0000;
    tick();
    chk("wrap_rel0", gnt, 4'b0000);
    req = 4'b0100;
    tick();
    chk_all("wrap_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("wrap_rel2", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    chk_all("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk("wrap_rel", gnt, 4'b0000);

`ifndef MUX4_ARB_TIMEOUT_EN
    // 4. hold: requester 1 keeps ownership while others request
    req = 4'b0010;
    tick();
    chk_all("hold_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_gnt", gnt, 4'b0010);
      chk("hold_sel", {2'b00, sel}, 4'd1);
    end
    req = 4'b1101;
    tick();
    chk_all("hold_release", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
`endif

    // 5. reset mid-grant with requester 3 owning
    req = 4'b1000;
    tick();
    chk_all("mid_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    reset = 1'b0;
    req   = 4'b1001;
    tick();
    chk_all("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("mid_after", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef MUX4_ARB_TIMEOUT_EN
    // 6. forced release after MAX_HOLD=4 cycles
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    chk_all("to_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk_all("to_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk_all("to_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0011;
    tick();
    chk_all("to_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk_all("to_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_all("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
